// File: rtl/ddr_resp_model.sv
// ddr_resp_model: block-RAM backed responder for the DDR user-side request
// interface, with programmable init and access latencies.
// Optional feature macro: DDR_RESP_STATS_EN (adds WrCount/RdCount outputs).
module ddr_resp_model #(
    parameter int unsigned INIT_CYCLES = 200,
    parameter int unsigned WR_LAT      = 4,
    parameter int unsigned RD_LAT      = 6,
    parameter int unsigned AW          = 8
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic        DDR_Ready,
    input  logic        DDR_WrStart,
    input  logic [1:0]  DDR_WrBank,
    input  logic [12:0] DDR_WrAddr,
    input  logic [15:0] DDR_WrData,
    output logic        DDR_WrReady,
    input  logic        DDR_RdStart,
    input  logic [1:0]  DDR_RdBank,
    input  logic [12:0] DDR_RdAddr,
    output logic [15:0] DDR_RdData,
`ifdef DDR_RESP_STATS_EN
    output logic        DDR_RdReady,
    output logic [15:0] WrCount,
    output logic [15:0] RdCount
`else
    output logic        DDR_RdReady
`endif
);

    localparam int unsigned IW      = AW + 2;
    localparam int unsigned DEPTH   = 1 << IW;
    localparam int unsigned MAX_A   = (INIT_CYCLES > WR_LAT) ? INIT_CYCLES : WR_LAT;
    localparam int unsigned MAX_LAT = (MAX_A > RD_LAT) ? MAX_A : RD_LAT;
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);

    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] WR_LAST   = CW'(WR_LAT - 1);
    localparam logic [CW-1:0] RD_LAST   = CW'(RD_LAT - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WRITE = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            ready_d, wr_ready_d, rd_ready_d;
    logic [15:0]     rd_data_d;

    logic            init_done_c, wr_acc_c, rd_acc_c, wr_done_c, rd_done_c;
    logic [15:0]     mem [0:DEPTH-1];

    // Upper address bits alias onto the same word and are deliberately unused
    logic            unused_addr_bits;
    assign unused_addr_bits = ^{DDR_WrAddr[12:AW], DDR_RdAddr[12:AW]};

    assign init_done_c = (state_q == ST_INIT)  && (cnt_q == INIT_LAST);
    assign wr_done_c   = (state_q == ST_WRITE) && (cnt_q == WR_LAST);
    assign rd_done_c   = (state_q == ST_READ)  && (cnt_q == RD_LAST);
    assign wr_acc_c    = (state_q == ST_IDLE) && DDR_WrStart && !DDR_WrReady;
    assign rd_acc_c    = (state_q == ST_IDLE) && DDR_RdStart && !DDR_RdReady && !wr_acc_c;

    // State and registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            DDR_Ready   <= 1'b0;
            DDR_WrReady <= 1'b0;
            DDR_RdReady <= 1'b0;
            DDR_RdData  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            DDR_Ready   <= ready_d;
            DDR_WrReady <= wr_ready_d;
            DDR_RdReady <= rd_ready_d;
            DDR_RdData  <= rd_data_d;
        end
    end

    // Next-state selection; write wins over a simultaneous read
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (init_done_c) state_d = ST_IDLE;
            ST_IDLE: begin
                if (wr_acc_c)      state_d = ST_WRITE;
                else if (rd_acc_c) state_d = ST_READ;
            end
            ST_WRITE: if (wr_done_c) state_d = ST_IDLE;
            ST_READ:  if (rd_done_c) state_d = ST_IDLE;
            default:  state_d = ST_INIT;
        endcase
    end

    // Next values of counter, request latches and outputs
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        ready_d    = DDR_Ready;
        wr_ready_d = DDR_WrReady && DDR_WrStart;
        rd_ready_d = DDR_RdReady && DDR_RdStart;
        rd_data_d  = DDR_RdData;
        case (state_q)
            ST_INIT: begin
                if (init_done_c) begin
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (wr_acc_c) begin
                    idx_d   = {DDR_WrBank, DDR_WrAddr[AW-1:0]};
                    wdata_d = DDR_WrData;
                end else if (rd_acc_c) begin
                    idx_d   = {DDR_RdBank, DDR_RdAddr[AW-1:0]};
                end
            end
            ST_WRITE: begin
                if (wr_done_c) begin
                    wr_ready_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_READ: begin
                if (rd_done_c) begin
                    rd_ready_d = 1'b1;
                    rd_data_d  = mem[idx_q];
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Storage array; no reset so contents survive Rst_n
    always_ff @(posedge Clk) begin
        if (wr_done_c) mem[idx_q] <= wdata_q;
    end

`ifdef DDR_RESP_STATS_EN
    // Completed-transaction counters, wrapping at 16 bits
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            WrCount <= 16'h0000;
            RdCount <= 16'h0000;
        end else begin
            if (wr_done_c) WrCount <= WrCount + 16'd1;
            if (rd_done_c) RdCount <= RdCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr_resp_model.sv
// Directed self-checking bench for ddr_resp_model (default parameters).
module tb_ddr_resp_model;

    localparam int unsigned INIT_CYCLES = 200;
    localparam int unsigned WR_LAT      = 4;
    localparam int unsigned RD_LAT      = 6;
    localparam int unsigned AW          = 8;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        DDR_Ready;
    logic        DDR_WrStart;
    logic [1:0]  DDR_WrBank;
    logic [12:0] DDR_WrAddr;
    logic [15:0] DDR_WrData;
    logic        DDR_WrReady;
    logic        DDR_RdStart;
    logic [1:0]  DDR_RdBank;
    logic [12:0] DDR_RdAddr;
    logic [15:0] DDR_RdData;
    logic        DDR_RdReady;
`ifdef DDR_RESP_STATS_EN
    logic [15:0] WrCount;
    logic [15:0] RdCount;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    ddr_resp_model #(
        .INIT_CYCLES(INIT_CYCLES),
        .WR_LAT(WR_LAT),
        .RD_LAT(RD_LAT),
        .AW(AW)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .DDR_Ready(DDR_Ready),
        .DDR_WrStart(DDR_WrStart),
        .DDR_WrBank(DDR_WrBank),
        .DDR_WrAddr(DDR_WrAddr),
        .DDR_WrData(DDR_WrData),
        .DDR_WrReady(DDR_WrReady),
        .DDR_RdStart(DDR_RdStart),
        .DDR_RdBank(DDR_RdBank),
        .DDR_RdAddr(DDR_RdAddr),
        .DDR_RdData(DDR_RdData),
`ifdef DDR_RESP_STATS_EN
        .DDR_RdReady(DDR_RdReady),
        .WrCount(WrCount),
        .RdCount(RdCount)
`else
        .DDR_RdReady(DDR_RdReady)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic edge1();
        @(posedge Clk);
        #1;
    endtask

    // Write with mid-flight input scrambling; checks latency and release
    task automatic do_write(input logic [1:0] b, input logic [12:0] a, input logic [15:0] d);
        int n;
        n = 0;
        DDR_WrBank = b; DDR_WrAddr = a; DDR_WrData = d; DDR_WrStart = 1'b1;
        do begin
            edge1();
            n++;
            if (n == 1) begin
                DDR_WrData = ~d; DDR_WrAddr = a ^ 13'h00FF; DDR_WrBank = ~b;
            end
        end while (DDR_WrReady !== 1'b1 && n < 40);
        check("wr_latency", 16'(n), 16'(WR_LAT + 1));
        DDR_WrStart = 1'b0;
        edge1();
        check("wr_release", 16'(DDR_WrReady), 16'h0000);
    endtask

    // Read with mid-flight input scrambling; checks latency, data and release
    task automatic do_read(input logic [1:0] b, input logic [12:0] a, input logic [15:0] exp);
        int n;
        n = 0;
        DDR_RdBank = b; DDR_RdAddr = a; DDR_RdStart = 1'b1;
        do begin
            edge1();
            n++;
            if (n == 1) begin
                DDR_RdAddr = a ^ 13'h00FF; DDR_RdBank = ~b;
            end
        end while (DDR_RdReady !== 1'b1 && n < 40);
        check("rd_latency", 16'(n), 16'(RD_LAT + 1));
        check("rd_data", DDR_RdData, exp);
        DDR_RdStart = 1'b0;
        edge1();
        check("rd_release", 16'(DDR_RdReady), 16'h0000);
        check("rd_hold", DDR_RdData, exp);
    endtask

    initial begin
        int n;
        Rst_n = 1'b0;
        DDR_WrStart = 1'b0; DDR_WrBank = '0; DDR_WrAddr = '0; DDR_WrData = '0;
        DDR_RdStart = 1'b0; DDR_RdBank = '0; DDR_RdAddr = '0;

        // Reset values
        #3;
        check("rst_ready", 16'(DDR_Ready), 16'h0000);
        check("rst_wrready", 16'(DDR_WrReady), 16'h0000);
        check("rst_rdready", 16'(DDR_RdReady), 16'h0000);
        check("rst_rddata", DDR_RdData, 16'h0000);
        #9 Rst_n = 1'b1;

        // Init window; write request raised during INIT at edge 1
        edge1();
        check("init_e1", 16'(DDR_Ready), 16'h0000);
        DDR_WrBank = 2'd0; DDR_WrAddr = 13'h0000; DDR_WrData = 16'hBABE; DDR_WrStart = 1'b1;
        for (int e = 2; e <= 200; e++) begin
            edge1();
            if (e < 200) check("init_not_ready", 16'(DDR_Ready), 16'h0000);
            else         check("init_ready_e200", 16'(DDR_Ready), 16'h0001);
            check("init_no_wr", 16'(DDR_WrReady), 16'h0000);
        end

        // Write accepted at edge 201, completes at 205
        for (int e = 201; e <= 204; e++) begin
            edge1();
            check("wr1_busy", 16'(DDR_WrReady), 16'h0000);
        end
        edge1();
        check("wr1_done_e205", 16'(DDR_WrReady), 16'h0001);
        DDR_RdBank = 2'd0; DDR_RdAddr = 13'h0000; DDR_RdStart = 1'b1;

        // Read accepted at 206, completes at 212
        for (int e = 206; e <= 211; e++) begin
            edge1();
            check("rd1_busy", 16'(DDR_RdReady), 16'h0000);
        end
        edge1();
        check("rd1_done_e212", 16'(DDR_RdReady), 16'h0001);
        check("rd1_data", DDR_RdData, 16'hBABE);
        check("wr1_held", 16'(DDR_WrReady), 16'h0001);
        DDR_WrStart = 1'b0;
        edge1();
        check("wr1_clear", 16'(DDR_WrReady), 16'h0000);
        check("rd1_still", 16'(DDR_RdReady), 16'h0001);
        DDR_RdStart = 1'b0;
        edge1();
        check("rd1_clear", 16'(DDR_RdReady), 16'h0000);
        check("rd1_hold", DDR_RdData, 16'hBABE);

        // Simultaneous write and read: write at 215..219, read at 220..226
        DDR_WrBank = 2'd2; DDR_WrAddr = 13'h0005; DDR_WrData = 16'h1234; DDR_WrStart = 1'b1;
        DDR_RdBank = 2'd2; DDR_RdAddr = 13'h0005; DDR_RdStart = 1'b1;
        for (int e = 215; e <= 218; e++) begin
            edge1();
            check("both_wr_busy", 16'(DDR_WrReady), 16'h0000);
        end
        edge1();
        check("both_wr_done", 16'(DDR_WrReady), 16'h0001);
        for (int e = 219; e <= 225; e++) begin
            if (e > 219) edge1();
            check("both_rd_busy", 16'(DDR_RdReady), 16'h0000);
        end
        edge1();
        check("both_rd_done", 16'(DDR_RdReady), 16'h0001);
        check("both_rd_data", DDR_RdData, 16'h1234);
        DDR_WrStart = 1'b0; DDR_RdStart = 1'b0;
        edge1();
        check("both_wr_clear", 16'(DDR_WrReady), 16'h0000);
        check("both_rd_clear", 16'(DDR_RdReady), 16'h0000);

        // Address aliasing and untouched bank
        do_write(2'd1, 13'h0010, 16'hAAAA);
        do_write(2'd1, 13'h0110, 16'h5555);
        do_read(2'd1, 13'h0010, 16'h5555);
        do_read(2'd3, 13'h0010, 16'h0000);

        // Reset two cycles into a write: not committed, INIT repeats
        do_write(2'd0, 13'h0003, 16'h0F0F);
        do_read(2'd0, 13'h0003, 16'h0F0F);
        DDR_WrBank = 2'd0; DDR_WrAddr = 13'h0003; DDR_WrData = 16'hDEAD; DDR_WrStart = 1'b1;
        edge1();
        edge1();
        edge1();
        Rst_n = 1'b0;
        DDR_WrStart = 1'b0;
        #1;
        check("mid_rst_ready", 16'(DDR_Ready), 16'h0000);
        check("mid_rst_wrready", 16'(DDR_WrReady), 16'h0000);
        check("mid_rst_rdready", 16'(DDR_RdReady), 16'h0000);
        check("mid_rst_rddata", DDR_RdData, 16'h0000);
        edge1();
        edge1();
        Rst_n = 1'b1;
        n = 0;
        do begin
            edge1();
            n++;
        end while (DDR_Ready !== 1'b1 && n < 400);
        check("reinit_cycles", 16'(n), 16'(INIT_CYCLES));
        do_read(2'd0, 13'h0003, 16'h0F0F);

`ifdef DDR_RESP_STATS_EN
        do_write(2'd0, 13'h0020, 16'h0001);
        do_write(2'd0, 13'h0021, 16'h0002);
        do_write(2'd0, 13'h0022, 16'h0003);
        do_read(2'd0, 13'h0021, 16'h0002);
        check("wr_count", WrCount, 16'd3);
        check("rd_count", RdCount, 16'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
